// File: rtl/lsu_master.sv
// lsu_master -- load/store initiator for the CPU M stage.
//
// Takes one memory instruction at a time from the pipeline. Each access is
// checked for alignment. An aligned access issues a registered, byte-enabled
// request on the data-memory bus and waits a variable time for bus_ack. While
// it waits, stall holds the pipeline. The unit then returns extended load data
// (ld_valid) or an exception (exc_valid) for exactly one cycle.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   op_valid            M stage holds a memory instruction
//   op_store            1 = store, 0 = load
//   op_size             00 word, 01 byte, 10 half, 11 word
//   op_unsigned         zero-extend loads (lbu/lhu)
//   op_addr, op_wdata   byte address, right-aligned store data
//   op_pc               PC of the instruction (reported on exceptions)
//   stall               combinational pipeline freeze
//   ld_valid, ld_data   load result (one cycle)
//   exc_valid, exc_code exception (one cycle): 01 misaligned load,
//                       10 misaligned store, 11 bus timeout
//   exc_pc              PC of the excepting instruction
//   bus_req/we/addr/be/wdata  registered request to the data memory
//   bus_ack, bus_rdata        responder completion and word read data
module lsu_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_store,
  input  logic [1:0]  op_size,
  input  logic        op_unsigned,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [31:0] op_pc,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  // The last REQ cycle before a timeout is declared.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;

  // Attributes of the in-flight op. These are kept so that the result path
  // does not depend on the op inputs once the request is out.
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        uns_q, uns_d;
  logic [31:0] pc_q, pc_d;

  logic        ld_valid_q, ld_valid_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_code_q, exc_code_d;
  logic [31:0] exc_pc_q, exc_pc_d;

  // Request decode from the op inputs
  logic        is_byte, is_half, is_word, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  always_comb begin
    is_byte    = (op_size == SZ_BYTE);
    is_half    = (op_size == SZ_HALF);
    is_word    = !is_byte && !is_half;
    misaligned = (is_word && (op_addr[1:0] != 2'b00)) || (is_half && op_addr[0]);
    if (is_byte) begin
      be_calc    = 4'b0001 << op_addr[1:0];
      wdata_calc = {4{op_wdata[7:0]}};
    end else if (is_half) begin
      be_calc    = op_addr[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{op_wdata[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = op_wdata;
    end
  end

  // Load lane extraction from the returned word
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (size_q == SZ_BYTE)
      ld_ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    else if (size_q == SZ_HALF)
      ld_ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
    else
      ld_ext = bus_rdata;
  end

  // Next-state and outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    store_d     = store_q;
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    pc_d        = pc_q;
    ld_valid_d  = 1'b0;
    ld_data_d   = ld_data_q;
    exc_valid_d = 1'b0;
    exc_code_d  = exc_code_q;
    exc_pc_d    = exc_pc_q;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          stall = 1'b1;
          if (misaligned) begin
            exc_valid_d = 1'b1;
            exc_code_d  = op_store ? 2'b10 : 2'b01;
            exc_pc_d    = op_pc;
            state_d     = S_DONE;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = op_store;
            bus_addr_d  = {op_addr[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wdata_calc;
            store_d     = op_store;
            size_d      = op_size;
            lane_d      = op_addr[1:0];
            uns_d       = op_unsigned;
            pc_d        = op_pc;
            cnt_d       = 8'd0;
            state_d     = S_REQ;
          end
        end
      end

      S_REQ: begin
        stall = 1'b1;
        // An ack in the final counted cycle still wins over the timeout.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!store_q) begin
            ld_data_d  = ld_ext;
            ld_valid_d = 1'b1;
          end
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          bus_req_d   = 1'b0;
          exc_valid_d = 1'b1;
          exc_code_d  = 2'b11;
          exc_pc_d    = pc_q;
          ld_data_d   = 32'b0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // The pipeline advances on the edge that leaves DONE, so the op is
      // never issued a second time.
      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'b0;
      bus_be_q    <= 4'b0;
      bus_wdata_q <= 32'b0;
      store_q     <= 1'b0;
      size_q      <= 2'b0;
      lane_q      <= 2'b0;
      uns_q       <= 1'b0;
      pc_q        <= 32'b0;
      ld_valid_q  <= 1'b0;
      ld_data_q   <= 32'b0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= 2'b0;
      exc_pc_q    <= 32'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      store_q     <= store_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      pc_q        <= pc_d;
      ld_valid_q  <= ld_valid_d;
      ld_data_q   <= ld_data_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
      exc_pc_q    <= exc_pc_d;
    end
  end

  assign ld_valid  = ld_valid_q;
  assign ld_data   = ld_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;
  assign exc_pc    = exc_pc_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Directed bench for lsu_master, built with TIMEOUT = 4. Inputs are driven at
// negedge+1. Outputs are checked one timestep later, well away from posedge.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_store, op_unsigned;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic        stall, ld_valid, exc_valid;
  logic [31:0] ld_data, exc_pc;
  logic [1:0]  exc_code;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int vectors = 0;
  int miscompares = 0;
  int stall_n = 0;

  lsu_master #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_store(op_store), .op_size(op_size),
    .op_unsigned(op_unsigned), .op_addr(op_addr), .op_wdata(op_wdata),
    .op_pc(op_pc), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%h exp=%h", vectors, tag, obs, exp);
  endtask

  // Count this cycle's stall, advance one clock, then settle at negedge+1.
  task automatic cyc();
    if (stall === 1'b1) stall_n++;
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc);
    op_valid = 1'b1; op_store = st; op_size = sz; op_unsigned = uns;
    op_addr = a; op_wdata = wd; op_pc = pc;
  endtask

  // Zero-wait load: IDLE -> REQ (ack) -> DONE, then check the result.
  task automatic load0(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    set_op(1'b0, sz, uns, a, 32'h0, 32'h0);
    #1; cyc();
    bus_ack = 1'b1; bus_rdata = rd;
    #1; cyc();
    bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(ld_valid), 32'd1);
    chk({tag, "_data"}, ld_data, exp);
    cyc();
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_store = 1'b0; op_size = 2'b00;
    op_unsigned = 1'b0; op_addr = 32'h0; op_wdata = 32'h0; op_pc = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_ldv", 32'(ld_valid), 32'd0);
    chk("rst_excv", 32'(exc_valid), 32'd0);
    chk("rst_code", 32'(exc_code), 32'd0);
    chk("rst_ldd", ld_data, 32'h0);

    // lb 0x1003, zero wait
    stall_n = 0;
    set_op(1'b0, 2'b01, 1'b0, 32'h0000_1003, 32'h0, 32'h100);
    #1; chk("lb_c1_stall", 32'(stall), 32'd1);
    cyc();
    chk("lb_req", 32'(bus_req), 32'd1);
    chk("lb_addr", bus_addr, 32'h0000_1000);
    chk("lb_be", 32'(bus_be), 32'h8);
    chk("lb_we", 32'(bus_we), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h80FF_1234;
    #1; cyc();
    bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("lb_ldv", 32'(ld_valid), 32'd1);
    chk("lb_data", ld_data, 32'hFFFF_FF80);
    chk("lb_excv", 32'(exc_valid), 32'd0);
    chk("lb_req_drop", 32'(bus_req), 32'd0);
    chk("lb_c3_stall", 32'(stall), 32'd0);
    cyc();
    chk("lb_stall_n", 32'(stall_n), 32'd2);
    chk("lb_ldv_1cyc", 32'(ld_valid), 32'd0);

    // lhu 0x0002, ack after 3 wait cycles (arrives in the last counted cycle)
    stall_n = 0;
    set_op(1'b0, 2'b10, 1'b1, 32'h0000_0002, 32'h0, 32'h104);
    #1; cyc();
    chk("lhu_be", 32'(bus_be), 32'hC);
    cyc(); cyc(); cyc();
    chk("lhu_req_w3", 32'(bus_req), 32'd1);
    bus_ack = 1'b1; bus_rdata = 32'h9ABC_5678;
    #1; cyc();
    bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("lhu_ldv", 32'(ld_valid), 32'd1);
    chk("lhu_data", ld_data, 32'h0000_9ABC);
    chk("lhu_excv", 32'(exc_valid), 32'd0);
    cyc();
    chk("lhu_stall_n", 32'(stall_n), 32'd5);

    // sb 0x0011
    set_op(1'b1, 2'b01, 1'b0, 32'h0000_0011, 32'h0000_00A5, 32'h108);
    #1; cyc();
    chk("sb_be", 32'(bus_be), 32'h2);
    chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(bus_we), 32'd1);
    chk("sb_addr", bus_addr, 32'h0000_0010);
    bus_ack = 1'b1;
    #1; cyc();
    bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("sb_ldv", 32'(ld_valid), 32'd0);
    chk("sb_excv", 32'(exc_valid), 32'd0);
    cyc();

    // misaligned lw 0x0006
    stall_n = 0;
    set_op(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h0000_3010);
    #1;
    chk("mlw_c1_req", 32'(bus_req), 32'd0);
    cyc();
    op_valid = 1'b0;
    #1;
    chk("mlw_req", 32'(bus_req), 32'd0);
    chk("mlw_excv", 32'(exc_valid), 32'd1);
    chk("mlw_code", 32'(exc_code), 32'd1);
    chk("mlw_pc", exc_pc, 32'h0000_3010);
    chk("mlw_ldv", 32'(ld_valid), 32'd0);
    cyc();
    chk("mlw_stall_n", 32'(stall_n), 32'd1);
    chk("mlw_excv_1cyc", 32'(exc_valid), 32'd0);

    // misaligned sh 0x0001
    set_op(1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'h1234, 32'h0000_3014);
    #1; cyc();
    op_valid = 1'b0;
    #1;
    chk("msh_excv", 32'(exc_valid), 32'd1);
    chk("msh_code", 32'(exc_code), 32'd2);
    chk("msh_req", 32'(bus_req), 32'd0);
    cyc();

    // sw with no ack -> timeout after TIMEOUT=4 REQ cycles
    stall_n = 0;
    set_op(1'b1, 2'b00, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_3020);
    #1; cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req_%0d", i), 32'(bus_req), 32'd1);
      cyc();
    end
    op_valid = 1'b0;
    #1;
    chk("to_req_drop", 32'(bus_req), 32'd0);
    chk("to_excv", 32'(exc_valid), 32'd1);
    chk("to_code", 32'(exc_code), 32'd3);
    chk("to_pc", exc_pc, 32'h0000_3020);
    chk("to_ldd", ld_data, 32'h0);
    chk("to_ldv", 32'(ld_valid), 32'd0);
    cyc();
    chk("to_stall_n", 32'(stall_n), 32'd5);
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    #1; cyc();
    bus_ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(bus_req), 32'd0);
    chk("late_ack_ldv", 32'(ld_valid), 32'd0);
    chk("late_ack_excv", 32'(exc_valid), 32'd0);
    chk("late_ack_stall", 32'(stall), 32'd0);

    // extra load patterns: signed half, word pass-through, lbu
    load0("lh", 2'b10, 1'b0, 32'h0000_0000, 32'h1234_8001, 32'hFFFF_8001);
    load0("lw", 2'b00, 1'b0, 32'h0000_0044, 32'h8765_4321, 32'h8765_4321);
    load0("lbu", 2'b01, 1'b1, 32'h0000_0001, 32'h0000_F200, 32'h0000_00F2);

    // reset in the 2nd REQ cycle with ack on the same edge
    set_op(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_3030);
    #1; cyc();
    cyc();
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    #1; cyc();
    reset = 1'b0; bus_ack = 1'b0; op_valid = 1'b0;
    #1;
    chk("rq_req", 32'(bus_req), 32'd0);
    chk("rq_ldv", 32'(ld_valid), 32'd0);
    chk("rq_excv", 32'(exc_valid), 32'd0);
    chk("rq_stall", 32'(stall), 32'd0);
    cyc();
    chk("rq_ldv2", 32'(ld_valid), 32'd0);
    chk("rq_excv2", 32'(exc_valid), 32'd0);
    chk("rq_req2", 32'(bus_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
